// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round count, Rcon lookup
// and word/byte slicing helpers used by the key schedule and the round datapath.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Rcon for rounds 1..10; 0 outside that range
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Word 0 / byte 0 sit in the most significant position
    function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] i);
        return blk[{~i, 5'd0} +: 32];
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] blk, input logic [3:0] i);
        return blk[{~i, 3'd0} +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197 table), shared with SubBytes.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[value];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: holds one round key and derives the next
// one in a single cycle each time the consumer accepts the current key.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    output logic         done
);

    localparam logic [3:0] LAST = 4'(NR);

    state_t state, state_nxt;
    logic   hs, last;

    assign hs   = rk_valid && rk_ready;
    assign last = (rk_round == LAST);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = EMIT;
            EMIT:    if (hs && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next-key derivation from the currently held key
    logic [31:0] w0, w1, w2, w3, rot, sub, t;
    logic [31:0] n0, n1, n2, n3;
    logic [127:0] rk_next;

    assign w0  = word_of(round_key, 2'd0);
    assign w1  = word_of(round_key, 2'd1);
    assign w2  = word_of(round_key, 2'd2);
    assign w3  = word_of(round_key, 2'd3);
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .value (rot[8*b +: 8]),
            .subst (sub[8*b +: 8])
        );
    end

    assign t  = sub ^ {rcon(rk_round + 4'd1), 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round_key <= '0;
            rk_round  <= '0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key;
                        rk_round  <= '0;
                        rk_valid  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        if (last) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            round_key <= rk_next;
                            rk_round  <= rk_round + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed and randomized checks of aes_key_expand against an S-box derived
// here from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [127:0] key;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_round;
    logic [127:0] round_key;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sb  [256];
    logic [127:0] cap [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .round_key (round_key),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] mdl_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
        t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Entered and left #1 after a rising edge; returns in the done cycle.
    task automatic stream(input logic [127:0] k, input int stall_pct, input bit inject);
        logic [127:0] exp_rk [11];
        logic [127:0] snap_rk;
        logic [3:0]   snap_rnd;
        logic [7:0]   rc;
        bit           stalled, rdy;
        int           idx, cyc;
        exp_rk[0] = k;
        rc = 8'h01;
        for (int i = 1; i < 11; i++) begin
            exp_rk[i] = mdl_next(exp_rk[i-1], rc);
            rc = gmul(rc, 8'h02);
        end
        key = k; start = 1'b1; rk_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 1; stalled = 1'b0;
        chk("done_low_first", 128'(done), 128'(0));
        while (idx <= 10 && cyc < 600) begin
            if (stalled) begin
                chk("stall_key",   round_key,       snap_rk);
                chk("stall_round", 128'(rk_round),  128'(snap_rnd));
                chk("stall_valid", 128'(rk_valid),  128'(1));
            end
            chk("busy_stream", 128'(busy), 128'(1));
            rdy = ($urandom_range(99, 0) >= stall_pct);
            rk_ready = rdy;
            if (inject && (rk_round == 4'd4 || (rk_round == 4'd10 && rdy))) begin
                start = 1'b1;
                key   = ~k;
            end
            if (rdy) begin
                chk("hs_valid", 128'(rk_valid), 128'(1));
                chk("hs_round", 128'(rk_round), 128'(idx));
                chk("hs_key",   round_key,      exp_rk[idx]);
                cap[idx] = round_key;
                idx++;
            end
            stalled  = !rdy;
            snap_rk  = round_key;
            snap_rnd = rk_round;
            @(posedge clk); #1;
            start = 1'b0; key = k;
            cyc++;
        end
        rk_ready = 1'b0;
        chk("stream_complete", 128'(idx), 128'(11));
        chk("done_pulse",  128'(done),     128'(1));
        chk("done_busy",   128'(busy),     128'(0));
        chk("done_valid",  128'(rk_valid), 128'(0));
        if (stall_pct == 0) chk("done_cycle", 128'(cyc), 128'(12));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 128'({busy, rk_valid, rk_round, done}), 128'(0));
        chk("rst_key",  round_key, 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 vector, back-to-back into the all-zero key from the done cycle
        stream(FIPS_KEY, 0, 1'b0);
        chk("fips_r0",  cap[0],  FIPS_KEY);
        chk("fips_r1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        stream(128'h0, 0, 1'b0);
        chk("zero_r1",  cap[1],  128'h62636363626363636263636362636363);
        chk("zero_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        @(posedge clk); #1;
        chk("done_one_cycle", 128'(done), 128'(0));

        stream(FIPS_KEY, 30, 1'b0);
        chk("bp_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        stream(FIPS_KEY, 0, 1'b1);
        chk("inj_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        stream(128'h0, 0, 1'b0);
        chk("after_inj_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Mid-stream reset at round 6
        key = FIPS_KEY; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rk_ready = 1'b1;
        for (int c = 0; c < 20 && rk_round != 4'd6; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_at_round6", 128'(rk_round), 128'(6));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_ctrl", 128'({busy, rk_valid, rk_round, done}), 128'(0));
        chk("midrst_key",  round_key, 128'(0));
        @(posedge clk); #1;
        chk("midrst_no_done", 128'({busy, done}), 128'(0));
        rk_ready = 1'b0;
        stream(FIPS_KEY, 0, 1'b0);
        chk("postrst_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);

        for (int n = 0; n < 1000; n++)
            stream({$urandom, $urandom, $urandom, $urandom}, 30, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
